mdu_unit: RTL and testbench
===========================

// Module: mdu_unit
// PURPOSE
//  Multiply/divide unit for the EX stage. Owns the architectural HI/LO registers.
//  Runs MULT/MULTU (pipelined), DIV/DIVU (iterative radix-2) and MTHI/MTLO.
//  Drives busy; the hazard stall unit consumes it as isbusy (stall when busy & RHL_visit).
//  Cancelled by flush, the MEM1 exception/eret flush.
// PARAMETERS
//  MUL_LAT  2   cycles from MULT start to HI/LO update; legal range 1..4
//  DIV_LAT  33  cycles from DIV start to HI/LO update (32 iterations + 1 sign fix); fixed
// PORTS
//  clk      in   1   clock, rising edge
//  rst      in   1   synchronous reset, active-high
//  start    in   1   EX holds a valid MDU op and ID_EXWr/EX_MEM1Wr advance this cycle
//  op       in   3   MDU_NOP/MULT/MULTU/DIV/DIVU/MTHI/MTLO (encodings from package)
//  rs_val   in   32  forwarded rs operand (dividend / multiplicand / MTxx data)
//  rt_val   in   32  forwarded rt operand (divisor / multiplier)
//  flush    in   1   MEM1_ex | MEM1_eret_flush; kills in-flight op
//  busy     out  1   operation in flight; HI/LO not yet valid
//  hi       out  32  HI register
//  lo       out  32  LO register
// BEHAVIOUR
//  Reset: hi=0, lo=0, busy=0, FSM=IDLE, iteration counter=0, operand regs=0.
//  FSM states and transitions:
//   IDLE -> MUL on start & MULT/MULTU & ~flush
//   IDLE -> DIV on start & DIV/DIVU & ~flush
//   MUL/DIV -> IDLE when counter hits LAT-1 (HI/LO written that edge), or on flush.
//  Timing: start sampled in cycle T. busy=1 in T+1..T+LAT. hi/lo take the result on the
//   edge ending T+LAT. busy=0 and the new value is visible in T+LAT+1.
//  MTHI/MTLO: when start in IDLE, hi/lo <= rs_val on the edge ending T; busy stays 0.
//  MULT: signed 32x32->64; MULTU: unsigned. {hi,lo} <= product.
//   Operands are registered at start. The product may be pipelined over MUL_LAT stages.
//  DIVU: restoring division over 32 iterations; cycle 33 writes lo=quotient, hi=remainder.
//  DIV: divides magnitudes. Quotient negated iff rs[31]^rt[31]; remainder takes sign of rs.
//   0x8000_0000 / 0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
//  Divide by zero (either op): lo=32'hFFFF_FFFF, hi=rs_val; full DIV_LAT latency kept.
//  Boundary conditions:
//   - start while busy: ignored, no state change (stall unit prevents it; bench asserts it never occurs).
//   - flush: takes priority over start and over completion in the same cycle.
//     hi/lo unchanged, FSM->IDLE, busy=0 next cycle.
//   - flush same cycle as MTHI/MTLO start: write suppressed.
//   - rst mid-operation: full reset values above, no HI/LO write.
//   - op=MDU_NOP with start: no effect.
// STRUCTURE
//  Package mdu_pkg: MDU_* op encodings, state encoding, DIV_LAT localparam.
//  Sub-module div_core: iterative unsigned divider.
//   Ports: clk, rst, go, kill, dividend, divisor -> quo, rem, done.
//  Sign pre/post-processing, multiplier pipeline, FSM and HI/LO registers stay in mdu_unit.
// TESTING
//  1. MULT rs=0xFFFF_FFFE(-2), rt=3 -> busy T+1..T+2; then hi=0xFFFF_FFFF, lo=0xFFFF_FFFA.
//  2. DIVU 100/7 -> busy exactly 33 cycles; then lo=14, hi=2.
//     DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
//  3. DIV 0x8000_0000/0xFFFF_FFFF -> lo=0x8000_0000, hi=0.
//     DIVU 5/0 -> lo=0xFFFF_FFFF, hi=5.
//  4. Start DIVU, assert flush at iteration 10 -> busy=0 next cycle, hi/lo keep prior values.
//     Repeat with flush on the completion cycle -> hi/lo still unchanged.
//  5. MTHI 0x1234 then MTLO 0xABCD on consecutive cycles -> hi=0x1234, lo=0xABCD, busy never 1.
//     MTLO with same-cycle flush -> lo unchanged.
//  6. rst asserted mid-DIV -> next cycle hi=lo=0, busy=0.
//     A new MULTU 0xFFFF_FFFF*2 then completes: hi=1, lo=0xFFFF_FFFE.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the fixed divide latency.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_NOP   = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2
   } mdu_state_e;

   localparam int DIV_LAT = 33;

   // Two's-complement magnitude when the operand is treated as signed.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      return (is_signed && v[31]) ? (32'd0 - v) : v;
   endfunction

endpackage

// File: rtl/mdu_unit_div_core.sv
// Iterative radix-2 restoring divider for unsigned 32-bit operands.
// go loads the operands; 32 iterations later done pulses for one cycle.
module div_core
   import mdu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        kill,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] quo,
   output logic [31:0] rem,
   output logic        done
);

   logic [31:0] dvs;
   logic [5:0]  iter;
   logic        running;
   logic [32:0] partial;
   logic [32:0] diff;

   assign partial = {rem, quo[31]};
   assign diff    = partial - {1'b0, dvs};

   // The quotient register doubles as the dividend shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         quo     <= '0;
         rem     <= '0;
         dvs     <= '0;
         iter    <= '0;
         running <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (kill) begin
            running <= 1'b0;
         end else if (go) begin
            quo     <= dividend;
            rem     <= '0;
            dvs     <= divisor;
            iter    <= '0;
            running <= 1'b1;
         end else if (running) begin
            if (!diff[32]) begin
               rem <= diff[31:0];
               quo <= {quo[30:0], 1'b1};
            end else begin
               rem <= partial[31:0];
               quo <= {quo[30:0], 1'b0};
            end
            iter <= iter + 6'd1;
            if (iter == 6'd31) begin
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO: pipelined multiply, iterative
// divide with sign fix-up, MTHI/MTLO, and flush cancellation.
module mdu_unit
   import mdu_pkg::*;
#(
   parameter int MUL_LAT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   mdu_state_e  state, state_n;
   logic [5:0]  cnt, cnt_n;
   logic [31:0] hi_n, lo_n;
   logic [31:0] op_a, op_b;
   logic        op_signed;
   logic        load_ops, load_signed, div_go;

   logic signed [32:0] a_ext, b_ext;
   logic signed [65:0] prod_full;
   logic [63:0]        prod_comb, mul_result;

   logic [31:0] div_quo, div_rem, div_lo, div_hi;
   logic        div_done, neg_q, neg_r, div_zero;

   assign busy = (state != ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hi        <= '0;
         lo        <= '0;
         op_a      <= '0;
         op_b      <= '0;
         op_signed <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         hi    <= hi_n;
         lo    <= lo_n;
         if (load_ops) begin
            op_a      <= rs_val;
            op_b      <= rt_val;
            op_signed <= load_signed;
         end
      end
   end

   // Extend by one bit so a single signed multiply covers MULT and MULTU.
   assign a_ext     = {op_signed & op_a[31], op_a};
   assign b_ext     = {op_signed & op_b[31], op_b};
   assign prod_full = 66'(a_ext) * 66'(b_ext);
   assign prod_comb = prod_full[63:0];

   generate
      if (MUL_LAT == 1) begin : g_mul_comb
         assign mul_result = prod_comb;
      end else begin : g_mul_pipe
         logic [63:0] stage [MUL_LAT-1];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < MUL_LAT-1; i++) stage[i] <= '0;
            end else begin
               stage[0] <= prod_comb;
               for (int i = 1; i < MUL_LAT-1; i++) stage[i] <= stage[i-1];
            end
         end
         assign mul_result = stage[MUL_LAT-2];
      end
   endgenerate

   div_core u_div (
      .clk      (clk),
      .rst      (rst),
      .go       (div_go),
      .kill     (flush),
      .dividend (mag32(rs_val, op == MDU_DIV)),
      .divisor  (mag32(rt_val, op == MDU_DIV)),
      .quo      (div_quo),
      .rem      (div_rem),
      .done     (div_done)
   );

   // Remainder follows the dividend's sign; quotient negates on sign mismatch.
   assign div_zero = (op_b == 32'd0);
   assign neg_q    = op_signed & (op_a[31] ^ op_b[31]);
   assign neg_r    = op_signed & op_a[31];
   assign div_lo   = div_zero ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - div_quo) : div_quo);
   assign div_hi   = div_zero ? op_a : (neg_r ? (32'd0 - div_rem) : div_rem);

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      hi_n        = hi;
      lo_n        = lo;
      load_ops    = 1'b0;
      load_signed = 1'b0;
      div_go      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start && !flush) begin
               case (op)
                  MDU_MULT, MDU_MULTU: begin
                     state_n     = ST_MUL;
                     cnt_n       = '0;
                     load_ops    = 1'b1;
                     load_signed = (op == MDU_MULT);
                  end
                  MDU_DIV, MDU_DIVU: begin
                     state_n     = ST_DIV;
                     cnt_n       = '0;
                     load_ops    = 1'b1;
                     load_signed = (op == MDU_DIV);
                     div_go      = 1'b1;
                  end
                  MDU_MTHI: hi_n = rs_val;
                  MDU_MTLO: lo_n = rs_val;
                  default: ;
               endcase
            end
         end
         ST_MUL: begin
            if (flush) begin
               state_n = ST_IDLE;
            end else if (cnt == 6'(MUL_LAT-1)) begin
               {hi_n, lo_n} = mul_result;
               state_n      = ST_IDLE;
            end else begin
               cnt_n = cnt + 6'd1;
            end
         end
         ST_DIV: begin
            if (flush) begin
               state_n = ST_IDLE;
            end else if (div_done) begin
               hi_n    = div_hi;
               lo_n    = div_lo;
               state_n = ST_IDLE;
            end else begin
               cnt_n = cnt + 6'd1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency, arithmetic corner
// cases, flush and reset cancellation, and MTHI/MTLO.
module tb_mdu_unit;
   import mdu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [2:0]  op = MDU_NOP;
   logic [31:0] rs_val = '0;
   logic [31:0] rt_val = '0;
   logic        flush = 1'b0;
   logic        busy;
   logic [31:0] hi, lo;

   int tests = 0;
   int fails = 0;

   mdu_unit #(.MUL_LAT(2)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .flush  (flush),
      .busy   (busy),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   // The stall unit must never let a new op reach the MDU while it is busy.
   always @(negedge clk) begin
      if (start && busy) begin
         fails++;
         $display("[TB] FAIL start_while_busy: start=%0b busy=%0b expected busy=0", start, busy);
      end
   end

   // Drive one start cycle; returns in the cycle after start was sampled.
   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(negedge clk);
      start = 1'b0; op = MDU_NOP;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      tests++; if (hi !== 32'h0) begin fails++; $display("[TB] FAIL reset_hi: got %h expected 00000000", hi); end
      tests++; if (lo !== 32'h0) begin fails++; $display("[TB] FAIL reset_lo: got %h expected 00000000", lo); end
   endtask

   task automatic test_mult;
      int n;
      issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
      wait_idle(n);
      tests++; if (n != 2) begin fails++; $display("[TB] FAIL mult_latency: got %0d expected 2", n); end
      tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL mult_hi: got %h expected ffffffff", hi); end
      tests++; if (lo !== 32'hFFFF_FFFA) begin fails++; $display("[TB] FAIL mult_lo: got %h expected fffffffa", lo); end
      issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      tests++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin fails++; $display("[TB] FAIL mult_neg1x2: got %h%h expected fffffffffffffffe", hi, lo); end
      issue(MDU_MULTU, 32'h8000_0001, 32'h0001_0000);
      wait_idle(n);
      tests++; if ({hi, lo} !== 64'h0000_8000_0001_0000) begin fails++; $display("[TB] FAIL multu_big: got %h%h expected 0000800000010000", hi, lo); end
   endtask

   task automatic test_div;
      int n;
      issue(MDU_DIVU, 32'd100, 32'd7);
      wait_idle(n);
      tests++; if (n != 33) begin fails++; $display("[TB] FAIL divu_latency: got %0d expected 33", n); end
      tests++; if (lo !== 32'd14) begin fails++; $display("[TB] FAIL divu_lo: got %h expected 0000000e", lo); end
      tests++; if (hi !== 32'd2) begin fails++; $display("[TB] FAIL divu_hi: got %h expected 00000002", hi); end
      issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_idle(n);
      tests++; if (lo !== 32'hFFFF_FFFD) begin fails++; $display("[TB] FAIL div_neg_lo: got %h expected fffffffd", lo); end
      tests++; if (hi !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL div_neg_hi: got %h expected ffffffff", hi); end
      issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE);
      wait_idle(n);
      tests++; if ({hi, lo} !== {32'd1, 32'hFFFF_FFFD}) begin fails++; $display("[TB] FAIL div_negdivisor: got hi=%h lo=%h expected hi=00000001 lo=fffffffd", hi, lo); end
      issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle(n);
      tests++; if (lo !== 32'h8000_0000) begin fails++; $display("[TB] FAIL div_minint_lo: got %h expected 80000000", lo); end
      tests++; if (hi !== 32'h0) begin fails++; $display("[TB] FAIL div_minint_hi: got %h expected 00000000", hi); end
      issue(MDU_DIVU, 32'd5, 32'd0);
      wait_idle(n);
      tests++; if (n != 33) begin fails++; $display("[TB] FAIL divzero_latency: got %0d expected 33", n); end
      tests++; if (lo !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL divzero_lo: got %h expected ffffffff", lo); end
      tests++; if (hi !== 32'd5) begin fails++; $display("[TB] FAIL divzero_hi: got %h expected 00000005", hi); end
      issue(MDU_DIV, 32'hFFFF_FFF0, 32'd0);
      wait_idle(n);
      tests++; if ({hi, lo} !== {32'hFFFF_FFF0, 32'hFFFF_FFFF}) begin fails++; $display("[TB] FAIL div_signed_zero: got hi=%h lo=%h expected hi=fffffff0 lo=ffffffff", hi, lo); end
   endtask

   task automatic test_mthi_mtlo;
      int busy_seen = 0;
      @(negedge clk);
      start = 1'b1; op = MDU_MTHI; rs_val = 32'h0000_1234;
      @(negedge clk);
      if (busy) busy_seen++;
      op = MDU_MTLO; rs_val = 32'h0000_ABCD;
      @(negedge clk);
      if (busy) busy_seen++;
      start = 1'b0; op = MDU_NOP;
      @(negedge clk);
      if (busy) busy_seen++;
      tests++; if (busy_seen != 0) begin fails++; $display("[TB] FAIL mtxx_busy: got %0d busy cycles expected 0", busy_seen); end
      tests++; if (hi !== 32'h0000_1234) begin fails++; $display("[TB] FAIL mthi: got %h expected 00001234", hi); end
      tests++; if (lo !== 32'h0000_ABCD) begin fails++; $display("[TB] FAIL mtlo: got %h expected 0000abcd", lo); end
      @(negedge clk);
      start = 1'b1; op = MDU_MTLO; rs_val = 32'hDEAD_BEEF; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; op = MDU_NOP; flush = 1'b0;
      tests++; if (lo !== 32'h0000_ABCD) begin fails++; $display("[TB] FAIL mtlo_flush: got %h expected 0000abcd", lo); end
      issue(MDU_NOP, 32'h1111_1111, 32'h2222_2222);
      tests++; if ({busy, hi, lo} !== {1'b0, 32'h0000_1234, 32'h0000_ABCD}) begin fails++; $display("[TB] FAIL nop_start: got busy=%b hi=%h lo=%h expected busy=0 hi=00001234 lo=0000abcd", busy, hi, lo); end
   endtask

   task automatic test_flush;
      issue(MDU_MTHI, 32'h0000_5555, 32'd0);
      issue(MDU_MTLO, 32'h0000_AAAA, 32'd0);
      issue(MDU_DIVU, 32'd100, 32'd7);
      repeat (9) @(negedge clk);
      tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL flush_mid_busy_before: got %b expected 1", busy); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_mid_busy: got %b expected 0", busy); end
      repeat (40) @(negedge clk);
      tests++; if ({hi, lo} !== {32'h0000_5555, 32'h0000_AAAA}) begin fails++; $display("[TB] FAIL flush_mid_hilo: got hi=%h lo=%h expected hi=00005555 lo=0000aaaa", hi, lo); end
      issue(MDU_DIVU, 32'd100, 32'd7);
      repeat (32) @(negedge clk);
      tests++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL flush_end_busy_before: got %b expected 1", busy); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL flush_end_busy: got %b expected 0", busy); end
      repeat (5) @(negedge clk);
      tests++; if ({hi, lo} !== {32'h0000_5555, 32'h0000_AAAA}) begin fails++; $display("[TB] FAIL flush_end_hilo: got hi=%h lo=%h expected hi=00005555 lo=0000aaaa", hi, lo); end
      issue(MDU_MULT, 32'd3, 32'd4);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if ({busy, hi, lo} !== {1'b0, 32'h0000_5555, 32'h0000_AAAA}) begin fails++; $display("[TB] FAIL flush_mult: got busy=%b hi=%h lo=%h expected busy=0 hi=00005555 lo=0000aaaa", busy, hi, lo); end
   endtask

   task automatic test_reset_mid_op;
      int n;
      issue(MDU_DIV, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      tests++; if ({busy, hi, lo} !== {1'b0, 32'h0, 32'h0}) begin fails++; $display("[TB] FAIL rst_mid_div: got busy=%b hi=%h lo=%h expected all zero", busy, hi, lo); end
      repeat (40) @(negedge clk);
      tests++; if ({hi, lo} !== 64'h0) begin fails++; $display("[TB] FAIL rst_no_late_write: got hi=%h lo=%h expected all zero", hi, lo); end
      issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
      wait_idle(n);
      tests++; if (n != 2) begin fails++; $display("[TB] FAIL multu_latency: got %0d expected 2", n); end
      tests++; if (hi !== 32'd1) begin fails++; $display("[TB] FAIL multu_hi: got %h expected 00000001", hi); end
      tests++; if (lo !== 32'hFFFF_FFFE) begin fails++; $display("[TB] FAIL multu_lo: got %h expected fffffffe", lo); end
   endtask

   task automatic test_back_to_back;
      int n;
      issue(MDU_MULTU, 32'd6, 32'd7);
      wait_idle(n);
      issue(MDU_DIVU, 32'hFFFF_FFFF, 32'h0001_0000);
      wait_idle(n);
      tests++; if ({hi, lo} !== {32'h0000_FFFF, 32'h0000_FFFF}) begin fails++; $display("[TB] FAIL b2b_divu: got hi=%h lo=%h expected hi=0000ffff lo=0000ffff", hi, lo); end
      issue(MDU_MULTU, 32'd6, 32'd7);
      wait_idle(n);
      tests++; if ({hi, lo} !== {32'd0, 32'd42}) begin fails++; $display("[TB] FAIL b2b_multu: got hi=%h lo=%h expected hi=00000000 lo=0000002a", hi, lo); end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_mthi_mtlo();
      test_flush();
      test_reset_mid_op();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
